// File: rtl/pe_feed_ctrl.sv
// pe_feed_ctrl: upstream feeder for one pe.
// Loads K_TAPS filter taps, streams len_i samples paired with the taps, then drains.
// Optional feature: define PE_FEED_PERF_EN to add stall_cnt_o (stalled STREAM cycles).
module pe_feed_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned K_TAPS    = 3,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              op_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              flt_valid_i,
    input  logic [DATA_W-1:0] flt_data_i,
    output logic              flt_ready_o,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] pe_in_o,
    output logic [DATA_W-1:0] pe_filter_o,
    output logic [1:0]        mode_o,
    output logic              activate_o,
    output logic              busy_o,
    output logic              done_o
`ifdef PE_FEED_PERF_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    localparam int unsigned TIDX_W = (K_TAPS > 1) ? $clog2(K_TAPS) : 1;
    localparam int unsigned DCNT_W = $clog2(DRAIN_CYC + 1);
    localparam logic [TIDX_W-1:0] TIDX_LAST = TIDX_W'(K_TAPS - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYC);

    localparam logic [1:0] MODE_LOAD = 2'd2;
    localparam logic [1:0] MODE_IDLE = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StDone
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_op;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic [TIDX_W-1:0]   r_tap_idx;
    logic [DCNT_W-1:0]   r_drain_cnt;
    logic [DATA_W-1:0]   r_taps [K_TAPS];
    logic [DATA_W-1:0]   r_pe_in;
    logic [DATA_W-1:0]   r_pe_filter;
    logic [1:0]          r_mode;
    logic                r_activate;

    logic                w_start_acc;
    logic                w_flt_hs;
    logic                w_in_hs;
    logic                w_tap_last;
    logic [LEN_W-1:0]    w_cnt_inc;
    logic                w_len_last;
    logic                w_drain_last;
    logic [TIDX_W-1:0]   w_tap_idx_nxt;

    assign w_start_acc   = (r_state == StIdle) && start_i;
    assign w_flt_hs      = (r_state == StLoad) && flt_valid_i;
    assign w_in_hs       = (r_state == StStream) && in_valid_i;
    assign w_tap_last    = (r_tap_idx == TIDX_LAST);
    assign w_tap_idx_nxt = w_tap_last ? '0 : r_tap_idx + 1'b1;
    assign w_cnt_inc     = r_cnt + 1'b1;
    assign w_len_last    = (w_cnt_inc == r_len);
    // The first DRAIN cycle carries the final beat, so DRAIN lasts DRAIN_CYC+1 cycles
    // to leave DRAIN_CYC idle cycles before done.
    assign w_drain_last  = (r_drain_cnt == DCNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        flt_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        unique case (r_state)
            StIdle: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = StLoad;
                end
            end
            StLoad: begin
                flt_ready_o = 1'b1;
                if (w_flt_hs && w_tap_last) begin
                    w_state_nxt = (r_len == '0) ? StDrain : StStream;
                end
            end
            StStream: begin
                in_ready_o = 1'b1;
                if (w_in_hs && w_len_last) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (w_drain_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                done_o      = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Job context, tap buffer, counters and registered pe beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_tap_idx   <= '0;
            r_drain_cnt <= '0;
            r_pe_in     <= '0;
            r_pe_filter <= '0;
            r_mode      <= MODE_IDLE;
            r_activate  <= 1'b0;
            for (int i = 0; i < K_TAPS; i++) begin
                r_taps[i] <= '0;
            end
        end else begin
            r_mode <= MODE_IDLE;
            if (w_start_acc) begin
                r_op       <= op_i;
                r_len      <= len_i;
                r_cnt      <= '0;
                r_tap_idx  <= '0;
                r_activate <= 1'b1;
            end else if (r_state == StDone) begin
                r_activate <= 1'b0;
            end
            if (r_state == StDrain) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
            if (w_flt_hs) begin
                r_taps[r_tap_idx] <= flt_data_i;
                r_pe_filter       <= flt_data_i;
                r_mode            <= MODE_LOAD;
                r_tap_idx         <= w_tap_idx_nxt;
            end
            if (w_in_hs) begin
                r_pe_in     <= in_data_i;
                r_pe_filter <= r_taps[r_tap_idx];
                r_mode      <= {1'b0, r_op};
                r_tap_idx   <= w_tap_idx_nxt;
                r_cnt       <= w_cnt_inc;
            end
        end
    end

    assign pe_in_o     = r_pe_in;
    assign pe_filter_o = r_pe_filter;
    assign mode_o      = r_mode;
    assign activate_o  = r_activate;

`ifdef PE_FEED_PERF_EN
    logic [15:0] r_stall_cnt;

    // Count STREAM cycles without a sample offered; saturates, held after the job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StStream) && !in_valid_i && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Self-checking bench for pe_feed_ctrl: directed jobs plus randomized jobs,
// compared against a job-level model of the expected pe beat sequence.
module tb_pe_feed_ctrl;

    localparam int DATA_W    = 8;
    localparam int K_TAPS    = 3;
    localparam int LEN_W     = 8;
    localparam int DRAIN_CYC = 2;
    localparam int BUDGET    = 300;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              op_i;
    logic [LEN_W-1:0]  len_i;
    logic              flt_valid_i;
    logic [DATA_W-1:0] flt_data_i;
    logic              flt_ready_o;
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] pe_in_o;
    logic [DATA_W-1:0] pe_filter_o;
    logic [1:0]        mode_o;
    logic              activate_o;
    logic              busy_o;
    logic              done_o;
`ifdef PE_FEED_PERF_EN
    logic [15:0]       stall_cnt_o;
`endif

    always #5 clk = ~clk;

    pe_feed_ctrl #(
        .DATA_W    (DATA_W),
        .K_TAPS    (K_TAPS),
        .LEN_W     (LEN_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .len_i       (len_i),
        .flt_valid_i (flt_valid_i),
        .flt_data_i  (flt_data_i),
        .flt_ready_o (flt_ready_o),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .pe_in_o     (pe_in_o),
        .pe_filter_o (pe_filter_o),
        .mode_o      (mode_o),
        .activate_o  (activate_o),
        .busy_o      (busy_o),
`ifdef PE_FEED_PERF_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .done_o      (done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Last values the pe pins must hold across idle cycles.
    logic [DATA_W-1:0] exp_in;
    logic [DATA_W-1:0] exp_flt;

    // Current job description.
    logic [DATA_W-1:0] j_taps [K_TAPS];
    logic [DATA_W-1:0] j_samp [$];
    int                j_bub  [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_activate"}, 32'(activate_o), 32'd0);
        check_eq({tag, "_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_mode"}, 32'(mode_o), 32'd3);
        check_eq({tag, "_flt_ready"}, 32'(flt_ready_o), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
        check_eq({tag, "_pe_in"}, 32'(pe_in_o), 32'(exp_in));
        check_eq({tag, "_pe_filter"}, 32'(pe_filter_o), 32'(exp_flt));
    endtask

    // Runs one job starting at a negedge with the DUT idle; ends at a negedge, idle again.
    // hs_prev: 0 none, 1 tap, 2 sample handshake on the preceding edge.
    task automatic run_job(input logic op, input bit rand_flt, input bit inject_start);
        int len       = j_samp.size();
        int ti        = 0;
        int si        = 0;
        int idle_cnt  = 0;
        int bub_left  = 0;
        int stall_exp = 0;
        int hs_prev   = 0;
        bit finished  = 0;
        bit injected  = 0;
        bit all_hs;
        bit exp_done;
        if (len > 0) bub_left = j_bub[0];
        start_i     = 1'b1;
        op_i        = op;
        len_i       = LEN_W'(len);
        flt_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            op_i    = 1'b0;
            len_i   = '0;
            // Observe the beat produced by the previous edge.
            if (hs_prev == 1) begin
                exp_flt = j_taps[ti-1];
                check_eq("load_mode", 32'(mode_o), 32'd2);
            end else if (hs_prev == 2) begin
                exp_in  = j_samp[si-1];
                exp_flt = j_taps[(si-1) % K_TAPS];
                check_eq("stream_mode", 32'(mode_o), 32'({1'b0, op}));
            end else begin
                check_eq("idle_mode", 32'(mode_o), 32'd3);
            end
            check_eq("pe_in", 32'(pe_in_o), 32'(exp_in));
            check_eq("pe_filter", 32'(pe_filter_o), 32'(exp_flt));
            all_hs   = (ti == K_TAPS) && (si == len);
            exp_done = all_hs && (hs_prev == 0) && (idle_cnt == DRAIN_CYC);
            check_eq("done", 32'(done_o), 32'(exp_done));
            if (all_hs && hs_prev == 0) idle_cnt++;
            check_eq("activate", 32'(activate_o), 32'd1);
            check_eq("busy", 32'(busy_o), 32'd1);
            check_eq("flt_ready", 32'(flt_ready_o), 32'(ti < K_TAPS));
            check_eq("in_ready", 32'(in_ready_o), 32'((ti == K_TAPS) && (si < len)));
            if (exp_done) finished = 1;
            // Drive the next edge.
            hs_prev     = 0;
            flt_valid_i = 1'b0;
            in_valid_i  = 1'b0;
            flt_data_i  = DATA_W'($urandom);
            in_data_i   = DATA_W'($urandom);
            if (ti < K_TAPS) begin
                if (!rand_flt || $urandom_range(0, 2) != 0) begin
                    flt_valid_i = 1'b1;
                    flt_data_i  = j_taps[ti];
                    hs_prev     = 1;
                    ti++;
                end
            end else if (si < len) begin
                if (bub_left > 0) begin
                    bub_left--;
                    stall_exp++;
                end else begin
                    in_valid_i = 1'b1;
                    in_data_i  = j_samp[si];
                    hs_prev    = 2;
                    si++;
                    if (si < len) bub_left = j_bub[si];
                end
                if (inject_start && !injected && si >= 1) begin
                    injected = 1;
                    start_i  = 1'b1;
                    op_i     = 1'b1;
                    len_i    = LEN_W'(9);
                end
            end
        end
        check_eq("job_complete", 32'(finished), 32'd1);
        flt_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        start_i     = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_done");
`ifdef PE_FEED_PERF_EN
        check_eq("stall_cnt", 32'(stall_cnt_o), 32'(stall_exp));
`else
        if (stall_exp < 0) $display("unexpected negative stall count");
`endif
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        op_i        = 1'b0;
        len_i       = '0;
        flt_valid_i = 1'b0;
        flt_data_i  = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        exp_in      = '0;
        exp_flt     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Conv job, no bubbles.
        j_taps = '{8'd1, 8'd2, 8'd3};
        j_samp = '{8'd8, 8'd9, 8'd10, 8'd11};
        j_bub  = '{0, 0, 0, 0};
        run_job(1'b0, 1'b0, 1'b0);

        // Bubbles of two cycles between samples.
        j_samp = '{8'd20, 8'd21, 8'd22};
        j_bub  = '{0, 2, 2};
        run_job(1'b1, 1'b0, 1'b0);

        // len = 0: load only, then drain.
        j_taps = '{8'd5, 8'd6, 8'd7};
        j_samp = {};
        j_bub  = {};
        run_job(1'b0, 1'b0, 1'b0);

        // start_i pulsed mid-STREAM is ignored.
        j_taps = '{8'd4, 8'd9, 8'd14};
        j_samp = '{8'd30, 8'd31, 8'd32, 8'd33};
        j_bub  = '{0, 1, 0, 0};
        run_job(1'b0, 1'b0, 1'b1);

        // Reset mid-LOAD after one tap.
        start_i = 1'b1;
        op_i    = 1'b0;
        len_i   = LEN_W'(2);
        @(negedge clk);
        start_i     = 1'b0;
        len_i       = '0;
        flt_valid_i = 1'b1;
        flt_data_i  = 8'h44;
        @(negedge clk);
        check_eq("midload_mode", 32'(mode_o), 32'd2);
        check_eq("midload_filter", 32'(pe_filter_o), 32'h44);
        flt_valid_i = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        exp_in  = '0;
        exp_flt = '0;
        check_idle_outputs("midload_rst");
        rst = 1'b0;
        j_taps = '{8'd1, 8'd2, 8'd3};
        j_samp = '{8'd50, 8'd51};
        j_bub  = '{0, 0};
        run_job(1'b1, 1'b0, 1'b0);

        // Randomized jobs.
        for (int n = 0; n < 10; n++) begin
            int len;
            for (int i = 0; i < K_TAPS; i++) j_taps[i] = DATA_W'($urandom);
            len = $urandom_range(0, 7);
            j_samp.delete();
            j_bub.delete();
            for (int i = 0; i < len; i++) begin
                j_samp.push_back(DATA_W'($urandom));
                j_bub.push_back($urandom_range(0, 2));
            end
            run_job(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
